gol_matrix_scan: RTL and testbench

Display stage directly downstream of the Game of Life top level. It consumes the 49-bit 7x7 `grid` and the 2-bit `game_state` and drives a row-multiplexed 7x7 LED matrix. At each frame boundary it snapshots the grid, which prevents tearing when a new generation arrives mid-scan. It also reports the live-cell population and a still-life (`stable`) flag for status logic.

---
 rtl/gol_matrix_scan.sv | 106 ++++++++++
 tb/tb_gol_matrix_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gol_matrix_scan.sv
// Row-multiplexed 7x7 LED scanner for the Game of Life grid. Snapshots the grid
// once per frame and reports live-cell population plus a still-life flag.
module gol_matrix_scan #(
   parameter int DWELL        = 1000,
   parameter int BLINK_FRAMES = 32
) (
   input  logic        clka,
   input  logic        rst_n,
   input  logic [48:0] grid,
   input  logic [1:0]  game_state,
   output logic [6:0]  row_n,
   output logic [6:0]  col,
   output logic        frame_start,
   output logic [5:0]  population,
   output logic        stable
);

   localparam int DW_W = $clog2(DWELL);
   localparam int FC_W = $clog2(BLINK_FRAMES + 1);

   typedef enum logic [1:0] {
      GS_STOP    = 2'd0,
      GS_PROGRAM = 2'd1,
      GS_RUN     = 2'd2,
      GS_PAUSE   = 2'd3
   } game_state_e;

   logic [DW_W-1:0] dwell_q, dwell_d;
   logic [2:0]      row_q, row_d;
   logic [48:0]     shadow_q;
   logic [5:0]      pop_q;
   logic            stable_q;
   logic [FC_W-1:0] fcount_q, fcount_d;
   logic            phase_q, phase_d;
   logic            snap;

   function automatic logic [5:0] popcount49(input logic [48:0] v);
      logic [5:0] s;
      s = '0;
      for (int i = 0; i < 49; i++) begin
         s = s + {5'd0, v[i]};
      end
      return s;
   endfunction

   assign snap = (row_q == 3'd0) && (dwell_q == '0);

   always_comb begin
      dwell_d  = dwell_q + DW_W'(1);
      row_d    = row_q;
      fcount_d = fcount_q;
      phase_d  = phase_q;
      if (dwell_q == DW_W'(DWELL - 1)) begin
         dwell_d = '0;
         row_d   = (row_q == 3'd6) ? 3'd0 : row_q + 3'd1;
      end
      // Blink phase advances only on frame boundaries so a frame is never split.
      if (snap) begin
         if (fcount_q == FC_W'(BLINK_FRAMES - 1)) begin
            fcount_d = '0;
            phase_d  = ~phase_q;
         end else begin
            fcount_d = fcount_q + FC_W'(1);
         end
      end
   end

   always_ff @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         dwell_q  <= '0;
         row_q    <= 3'd0;
         shadow_q <= '0;
         pop_q    <= '0;
         stable_q <= 1'b0;
         fcount_q <= '0;
         phase_q  <= 1'b0;
      end else begin
         dwell_q  <= dwell_d;
         row_q    <= row_d;
         fcount_q <= fcount_d;
         phase_q  <= phase_d;
         if (snap) begin
            shadow_q <= grid;
            pop_q    <= popcount49(grid);
            stable_q <= (grid == shadow_q) && (game_state == GS_RUN);
         end
      end
   end

   // Outputs come from registered state; dwell 0 blanks the matrix between rows.
   always_comb begin
      frame_start = snap;
      row_n       = 7'h7F;
      col         = 7'h00;
      if (dwell_q != '0) begin
         row_n = ~(7'd1 << row_q);
         if (!((game_state == GS_PROGRAM) && phase_q)) begin
            col = shadow_q[row_q*7 +: 7];
         end
      end
   end

   assign population = pop_q;
   assign stable     = stable_q;

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Bench for gol_matrix_scan: frame-level reference model feeding an expected
// queue, with a monitor that checks every displayed cycle against it.
module tb_gol_matrix_scan;

   localparam int DWELL = 4;
   localparam int BLINK = 2;
   localparam int FRAME = 7 * DWELL;
   localparam logic [1:0] ST_STOP = 2'd0, ST_PROG = 2'd1, ST_RUN = 2'd2, ST_PAUSE = 2'd3;

   logic        clka = 1'b0;
   logic        rst_n = 1'b0;
   logic [48:0] grid = '0;
   logic [1:0]  game_state = ST_STOP;
   logic [6:0]  row_n, col;
   logic        frame_start;
   logic [5:0]  population;
   logic        stable;

   gol_matrix_scan #(.DWELL(DWELL), .BLINK_FRAMES(BLINK)) dut (
      .clka(clka),
      .rst_n(rst_n),
      .grid(grid),
      .game_state(game_state),
      .row_n(row_n),
      .col(col),
      .frame_start(frame_start),
      .population(population),
      .stable(stable)
   );

   always #5 clka = ~clka;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: position in frame, snapshots taken since reset.
   int          pos = 0;
   int          nsnaps = 0;
   logic [48:0] prev_snap = '0;
   logic        m_stable, m_phase;
   logic [56:0] exp_q[$];

   // Record currently being displayed, as seen by the monitor.
   logic [48:0] cur_snap = '0;
   logic [5:0]  cur_pop = '0;
   logic        cur_stable = 1'b0;
   logic        cur_phase = 1'b0;
   int          mon_row, mon_dw;
   logic [6:0]  exp_rn, exp_col;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Frame-level model: each snapshot edge yields one expected frame record.
   always @(posedge clka or negedge rst_n) begin
      if (!rst_n) begin
         pos       = 0;
         nsnaps    = 0;
         prev_snap = '0;
         exp_q.delete();
      end else begin
         if (pos == 0) begin
            nsnaps++;
            m_stable  = (grid == prev_snap) && (game_state == ST_RUN);
            m_phase   = ((nsnaps / BLINK) % 2) == 1;
            exp_q.push_back({grid, 6'($countones(grid)), m_stable, m_phase});
            prev_snap = grid;
         end
         pos = (pos + 1) % FRAME;
      end
   end

   // Monitor: samples on the falling edge, pops a record as each frame starts lighting.
   always @(negedge clka) begin
      if (!rst_n) begin
         cur_snap   = '0;
         cur_pop    = '0;
         cur_stable = 1'b0;
         cur_phase  = 1'b0;
         check("rst_row_n", row_n, 7'h7F);
         check("rst_col", col, 7'h00);
         check("rst_frame_start", frame_start, 1'b1);
         check("rst_population", population, 6'd0);
         check("rst_stable", stable, 1'b0);
      end else begin
         if (pos == 1) begin
            check("exp_queue_depth", exp_q.size(), 1);
            if (exp_q.size() != 0) {cur_snap, cur_pop, cur_stable, cur_phase} = exp_q.pop_front();
         end
         mon_row = pos / DWELL;
         mon_dw  = pos % DWELL;
         exp_rn  = 7'h7F;
         exp_col = 7'h00;
         if (mon_dw != 0) begin
            exp_rn[mon_row] = 1'b0;
            if (!(game_state == ST_PROG && cur_phase)) exp_col = cur_snap[mon_row*7 +: 7];
         end
         check("frame_start", frame_start, pos == 0);
         check("row_n", row_n, exp_rn);
         check("col", col, exp_col);
         check("population", population, cur_pop);
         check("stable", stable, cur_stable);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clka);
      #1;
   endtask

   task automatic wait_pos(input int p);
      bit found = 1'b0;
      for (int i = 0; i < FRAME + 2 && !found; i++) begin
         @(posedge clka);
         #1;
         if (pos == p) found = 1'b1;
      end
      check("wait_pos_timeout", found, 1'b1);
   endtask

   task automatic measure_period();
      int n = 0;
      bit seen = 1'b0;
      for (int i = 0; i < FRAME + 2 && !seen; i++) begin
         @(negedge clka);
         if (frame_start) seen = 1'b1;
      end
      seen = 1'b0;
      for (int i = 0; i < 2 * FRAME && !seen; i++) begin
         @(negedge clka);
         n++;
         if (frame_start) seen = 1'b1;
      end
      check("frame_start_period", n, FRAME);
   endtask

   function automatic logic [48:0] rand_grid();
      case ($urandom_range(0, 9))
         0:       return '0;
         1:       return '1;
         default: return 49'({$urandom(), $urandom()});
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   localparam logic [48:0] BLOCK = (49'd1 << 8) | (49'd1 << 9) | (49'd1 << 15) | (49'd1 << 16);

   initial begin
      repeat (3) @(posedge clka);
      #1 rst_n = 1'b1;
      grid = rand_grid() | 49'd1;
      game_state = ST_RUN;
      tick(2 * FRAME);

      // Reset in the middle of row 3 blanks immediately; restart is a snapshot cycle.
      wait_pos(3 * DWELL + 2);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_row_n", row_n, 7'h7F);
      check("midreset_col", col, 7'h00);
      check("midreset_population", population, 6'd0);
      check("midreset_frame_start", frame_start, 1'b1);
      @(posedge clka);
      #1 rst_n = 1'b1;
      @(negedge clka);
      check("first_cycle_frame_start", frame_start, 1'b1);
      @(negedge clka);
      check("first_lit_row_n", row_n, 7'h7E);
      tick(FRAME);

      // Corner cells.
      game_state = ST_STOP;
      grid = (49'd1 << 0) | (49'd1 << 48);
      tick(2 * FRAME);
      check("corner_population", population, 6'd2);

      // Grid change mid-scan must not tear the frame.
      grid = '0;
      tick(FRAME);
      wait_pos(2 * DWELL + 1);
      grid = '1;
      tick(2 * FRAME);
      check("tear_population", population, 6'd49);

      // Still-life detection.
      game_state = ST_RUN;
      grid = BLOCK;
      wait_pos(1);
      check("still_first", stable, 1'b0);
      wait_pos(1);
      check("still_second", stable, 1'b1);
      game_state = ST_PAUSE;
      wait_pos(1);
      check("still_pause", stable, 1'b0);
      game_state = ST_RUN;
      wait_pos(1);
      check("still_resume", stable, 1'b1);
      grid = BLOCK ^ (49'd1 << 8);
      wait_pos(1);
      check("still_flip", stable, 1'b0);

      // Changes presented in the snapshot cycle itself are captured by it.
      wait_pos(0);
      grid = 49'h1_2345_6789_ABCD;
      game_state = ST_RUN;
      tick(FRAME);

      // PROGRAM blink across several frames.
      game_state = ST_PROG;
      grid = 49'h0_AAAA_5555_AAAA | 49'd1;
      for (int f = 0; f < 6; f++) begin
         wait_pos(2);
         check("blink_row_scan", row_n, 7'h7E);
      end

      // Randomised sweep.
      for (int f = 0; f < 100; f++) begin
         if ($urandom_range(0, 3) == 0) game_state = 2'($urandom_range(0, 3));
         for (int c = 0; c < FRAME; c++) begin
            if ($urandom_range(0, 9) == 0) grid = rand_grid();
            tick(1);
         end
         if (f % 20 == 0) measure_period();
      end

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
